// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller for the miriscv core: per-channel level/edge pending logic,
// fixed-priority or round-robin arbitration, and a two-state service handshake with mret.
module miriscv_irq_ctrl #(
    parameter int               N_IRQ     = 32,
    parameter int               ARB_MODE  = 0,
    parameter logic [N_IRQ-1:0] EDGE_SENS = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [31:0]      mie_i,
    input  logic             int_rst_i,
    output logic             int_o,
    output logic [31:0]      mcause_o,
    output logic [N_IRQ-1:0] irq_ack_o
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t           state_q;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pend_q;
    logic [N_IRQ-1:0] pend_d;
    logic [N_IRQ-1:0] cand;
    logic [N_IRQ-1:0] clr;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] winner;
    logic             found;
    logic             svc_exit;

    assign svc_exit = (state_q == SERVICE) && int_rst_i;
    assign cand     = pend_q & mie_i[N_IRQ-1:0];

    // mie bits above the implemented channels are deliberately ignored
    if (N_IRQ < 32) begin : g_mie_hi
        logic unused_mie_hi;
        assign unused_mie_hi = ^mie_i[31:N_IRQ];
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        clr    = '0;
        pend_d = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            clr[k] = svc_exit && (idx_q == IDX_W'(k));
            // A fresh rising edge beats a simultaneous acknowledge clear.
            if (EDGE_SENS[k]) pend_d[k] = (irq_i[k] & ~irq_q[k]) | (pend_q[k] & ~clr[k]);
            else              pend_d[k] = irq_i[k];
        end
    end

    always_comb begin
        int j;
        found  = 1'b0;
        winner = '0;
        j      = 0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < N_IRQ; i++) begin
                if (!found && cand[i]) begin
                    found  = 1'b1;
                    winner = IDX_W'(i);
                end
            end
        end else begin
            // Rotating search begins just after the last channel served.
            for (int i = 0; i < N_IRQ; i++) begin
                j = int'(last_q) + 1 + i;
                if (j >= N_IRQ) j = j - N_IRQ;
                if (!found && cand[j]) begin
                    found  = 1'b1;
                    winner = IDX_W'(j);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_q  <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= irq_i;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            last_q    <= IDX_W'(N_IRQ - 1);
            int_o     <= 1'b0;
            mcause_o  <= '0;
            irq_ack_o <= '0;
        end else begin
            int_o     <= 1'b0;
            irq_ack_o <= '0;
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q  <= SERVICE;
                        idx_q    <= winner;
                        int_o    <= 1'b1;
                        mcause_o <= {1'b1, 26'b0, 5'(winner)};
                    end
                end
                SERVICE: begin
                    if (int_rst_i) begin
                        state_q   <= IDLE;
                        last_q    <= idx_q;
                        irq_ack_o <= clr;
                        mcause_o  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Scoreboard bench for miriscv_irq_ctrl: fixed/edge instance, round-robin instance and a
// single-channel instance; a negedge monitor pops expected int/ack events and compares.
module tb_miriscv_irq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] a_irq, a_mie, a_mcause, a_ack;
    logic        a_int_rst, a_int;
    logic [31:0] b_irq, b_mie, b_mcause, b_ack;
    logic        b_int_rst, b_int;
    logic [0:0]  c_irq, c_ack;
    logic [31:0] c_mie, c_mcause;
    logic        c_int_rst, c_int;

    miriscv_irq_ctrl #(.N_IRQ(32), .ARB_MODE(0), .EDGE_SENS(32'h0000_0028)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .irq_i(a_irq), .mie_i(a_mie), .int_rst_i(a_int_rst),
        .int_o(a_int), .mcause_o(a_mcause), .irq_ack_o(a_ack));

    miriscv_irq_ctrl #(.N_IRQ(32), .ARB_MODE(1), .EDGE_SENS(32'h0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .irq_i(b_irq), .mie_i(b_mie), .int_rst_i(b_int_rst),
        .int_o(b_int), .mcause_o(b_mcause), .irq_ack_o(b_ack));

    miriscv_irq_ctrl #(.N_IRQ(1), .ARB_MODE(0), .EDGE_SENS(1'b0)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .irq_i(c_irq), .mie_i(c_mie), .int_rst_i(c_int_rst),
        .int_o(c_int), .mcause_o(c_mcause), .irq_ack_o(c_ack));

    int n_checks = 0;
    int n_fail   = 0;

    // Entry format: {is_ack, value}; value is mcause for an int pulse, the ack vector otherwise.
    logic [32:0] qa[$];
    logic [32:0] qb[$];
    logic [32:0] qc[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic observe(input int id, input string name, input logic [32:0] got);
        logic [32:0] exp;
        int          sz;
        case (id)
            0:       sz = qa.size();
            1:       sz = qb.size();
            default: sz = qc.size();
        endcase
        if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got %h expected no output", name, got);
        end else begin
            case (id)
                0:       exp = qa.pop_front();
                1:       exp = qb.pop_front();
                default: exp = qc.pop_front();
            endcase
            check(name, 64'(got), 64'(exp));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_int)        observe(0, "a_event_int", {1'b0, a_mcause});
            if (a_ack != '0)  observe(0, "a_event_ack", {1'b1, a_ack});
            if (b_int)        observe(1, "b_event_int", {1'b0, b_mcause});
            if (b_ack != '0)  observe(1, "b_event_ack", {1'b1, b_ack});
            if (c_int)        observe(2, "c_event_int", {1'b0, c_mcause});
            if (c_ack != '0)  observe(2, "c_event_ack", {1'b1, 31'b0, c_ack});
        end
    end

    task automatic wait_int(input int id, input int budget, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            case (id)
                0:       seen = a_int;
                1:       seen = b_int;
                default: seen = c_int;
            endcase
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_int_%0d: got no int_o within %0d cycles expected a pulse", id, budget);
        end
    endtask

    // One-cycle int_rst strobe; irq lines take irq_with during it and irq_after afterwards.
    task automatic end_service(input int id, input logic [31:0] irq_with, input logic [31:0] irq_after);
        @(posedge clk); #1;
        case (id)
            0:       begin a_int_rst = 1'b1; a_irq = irq_with; end
            1:       begin b_int_rst = 1'b1; b_irq = irq_with; end
            default: begin c_int_rst = 1'b1; c_irq = irq_with[0]; end
        endcase
        @(posedge clk); #1;
        case (id)
            0:       begin a_int_rst = 1'b0; a_irq = irq_after; end
            1:       begin b_int_rst = 1'b0; b_irq = irq_after; end
            default: begin c_int_rst = 1'b0; c_irq = irq_after[0]; end
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        a_irq = '0; a_mie = '0; a_int_rst = 1'b0;
        b_irq = '0; b_mie = '0; b_int_rst = 1'b0;
        c_irq = '0; c_mie = '0; c_int_rst = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("a_rst_int", a_int, 0);    check("a_rst_mcause", a_mcause, 0); check("a_rst_ack", a_ack, 0);
        check("b_rst_int", b_int, 0);    check("b_rst_mcause", b_mcause, 0); check("b_rst_ack", b_ack, 0);
        check("c_rst_int", c_int, 0);    check("c_rst_mcause", c_mcause, 0); check("c_rst_ack", c_ack, 0);
        rst_n = 1'b1;

        // Fixed priority: channels 2 and 4 pending, 2 wins; latency from sampling edge
        @(posedge clk); #1;
        a_mie = 32'hFFFF_FFFF;
        a_irq = 32'h0000_0014;
        qa.push_back({1'b0, 32'h8000_0002});
        wait_int(0, 10, n);
        check("a_latency", n, 3);
        repeat (2) begin
            @(negedge clk);
            check("a_mcause_hold", a_mcause, 32'h8000_0002);
            check("a_int_single", a_int, 0);
        end
        qa.push_back({1'b1, 32'h0000_0004});
        end_service(0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        // Round-robin between two held level sources
        @(posedge clk); #1;
        b_mie = 32'hFFFF_FFFF;
        b_irq = 32'h0000_0003;
        for (int i = 0; i < 4; i++) begin
            qb.push_back({1'b0, (i % 2 == 0) ? 32'h8000_0000 : 32'h8000_0001});
            qb.push_back({1'b1, (i % 2 == 0) ? 32'h0000_0001 : 32'h0000_0002});
        end
        for (int i = 0; i < 4; i++) begin
            wait_int(1, 10, n);
            end_service(1, (i == 3) ? 32'h0 : 32'h3, (i == 3) ? 32'h0 : 32'h3);
        end
        repeat (4) @(negedge clk);

        // Masked edge on channel 3 stays latched, serviced once after unmasking
        @(posedge clk); #1;
        a_mie = 32'h0;
        a_irq = 32'h0000_0008;
        @(posedge clk); #1;
        a_irq = 32'h0;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        a_mie = 32'h0000_0008;
        qa.push_back({1'b0, 32'h8000_0003});
        wait_int(0, 10, n);
        qa.push_back({1'b1, 32'h0000_0008});
        end_service(0, 32'h0, 32'h0);
        repeat (5) @(negedge clk);

        // New edge on channel 5 coinciding with its acknowledge clear
        @(posedge clk); #1;
        a_mie = 32'h0000_0020;
        a_irq = 32'h0000_0020;
        @(posedge clk); #1;
        a_irq = 32'h0;
        qa.push_back({1'b0, 32'h8000_0005});
        qa.push_back({1'b1, 32'h0000_0020});
        qa.push_back({1'b0, 32'h8000_0005});
        qa.push_back({1'b1, 32'h0000_0020});
        wait_int(0, 10, n);
        end_service(0, 32'h0000_0020, 32'h0);
        wait_int(0, 10, n);
        end_service(0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        // Asynchronous reset during service: outputs clear at once, no ack afterwards
        @(posedge clk); #1;
        a_mie = 32'h0000_0001;
        a_irq = 32'h0000_0001;
        qa.push_back({1'b0, 32'h8000_0000});
        wait_int(0, 10, n);
        #2;
        rst_n = 1'b0;
        a_irq = 32'h0;
        #1;
        check("a_async_int", a_int, 0);
        check("a_async_mcause", a_mcause, 0);
        check("a_async_ack", a_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Edge line already high at reset release counts as a rising edge
        #2;
        rst_n = 1'b0;
        a_mie = 32'h0000_0008;
        a_irq = 32'h0000_0008;
        qa.push_back({1'b0, 32'h8000_0003});
        @(negedge clk);
        rst_n = 1'b1;
        wait_int(0, 10, n);
        qa.push_back({1'b1, 32'h0000_0008});
        end_service(0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);

        // Single channel: int_rst in IDLE ignored, then one service
        @(posedge clk); #1;
        c_mie = 32'h0000_0001;
        end_service(2, 32'h0, 32'h0);
        @(negedge clk);
        check("c_idle_int", c_int, 0);
        check("c_idle_mcause", c_mcause, 0);
        @(posedge clk); #1;
        c_irq = 1'b1;
        qc.push_back({1'b0, 32'h8000_0000});
        wait_int(2, 10, n);
        @(negedge clk);
        check("c_mcause_hold", c_mcause, 32'h8000_0000);
        qc.push_back({1'b1, 32'h0000_0001});
        end_service(2, 32'h0, 32'h0);
        repeat (5) @(negedge clk);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        check("qc_drained", qc.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/miriscv_irq_ctrl.md
MIRISCV_IRQ_CTRL -- requirements
Module: miriscv_irq_ctrl

Interface
REQ-001 Parameter N_IRQ, default 32, number of interrupt channels, legal range 1..32.
REQ-002 Parameter ARB_MODE, default 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
REQ-003 Parameter EDGE_SENS, default all zeros, N_IRQ-bit per-channel mask: 1 = rising-edge sensitive, 0 = level sensitive.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-006 irq_i  input  N_IRQ  raw interrupt request lines from peripherals.
REQ-007 mie_i  input  32  enable mask from the core CSR mie; bits at N_IRQ and above are ignored.
REQ-008 int_rst_i  input  1  end-of-handler strobe from the core, one cycle, issued on mret.
REQ-009 int_o  output  1  interrupt request pulse to the core.
REQ-010 mcause_o  output  32  cause of the interrupt in service.
REQ-011 irq_ack_o  output  N_IRQ  one-hot, one-cycle acknowledge to the serviced source.

Function
REQ-012 The pending register pend_q[N_IRQ-1:0] shall update every cycle.
- Level channel: pend_q[k] <= irq_i[k].
- Edge channel: pend_q[k] set when irq_i[k] & ~irq_q[k]; cleared only by its own acknowledge.
- irq_q is irq_i registered.
REQ-013 A new edge and a clear on the same edge channel in the same cycle shall leave pend_q[k] set.
REQ-014 The candidate vector shall be pend_q & mie_i[N_IRQ-1:0]. A masked edge bit shall stay latched and become eligible when it is unmasked.
REQ-015 The FSM shall have two states, IDLE and SERVICE.
- IDLE -> SERVICE when the candidate vector is non-zero; the winner index is latched into idx_q on that edge.
- SERVICE -> IDLE on int_rst_i.
REQ-016 In fixed-priority mode the lowest candidate index shall win.
REQ-017 In round-robin mode the search shall start at last_q+1 and wrap modulo N_IRQ. last_q shall load idx_q on each SERVICE exit.
REQ-018 int_o shall be high for exactly the first cycle of SERVICE and low at all other times.
REQ-019 mcause_o shall equal {1'b1, 26'b0, idx_q[4:0]} throughout SERVICE and 0 in IDLE.
REQ-020 On SERVICE exit, irq_ack_o[idx_q] shall pulse for one cycle and edge bit pend_q[idx_q] shall clear.
REQ-021 A level channel shall not be cleared by the controller; the source must drop irq_i after irq_ack_o.
REQ-022 Latency: irq_i sampled at edge k, enabled, FSM idle -> int_o high in the cycle after edge k+1.
REQ-023 The earliest re-arbitration shall be the cycle after the return to IDLE, giving int_o no sooner than 2 cycles after int_rst_i.
REQ-024 In IDLE, int_rst_i shall be ignored.
REQ-025 In SERVICE:
- new requests shall only update pend_q;
- changes to mie_i shall not abort service;
- no nesting is permitted.
REQ-026 Index width shall be max(1,$clog2(N_IRQ)). With N_IRQ=1, idx_q shall always be 0.

Reset
REQ-027 When rst_n_i is low, independent of clk_i:
- state = IDLE; pend_q, irq_q, idx_q = 0; last_q = N_IRQ-1;
- int_o = 0, mcause_o = 0, irq_ack_o = 0.
REQ-028 Reset asserted during SERVICE shall abandon the service without any acknowledge.
REQ-029 An edge line already high at reset release shall count as a rising edge.

Verification
REQ-030 Fixed mode, all enabled, irq_i = 0x0000_0014 held -> int_o pulse; mcause_o = 0x8000_0002 until int_rst_i; then irq_ack_o = 0x4.
REQ-031 Round-robin, level sources 0 and 1 held high, int_rst_i issued each service -> mcause_o sequence 0x80000000, 0x80000001, 0x80000000, 0x80000001.
REQ-032 Edge channel 3 pulses once while mie_i[3]=0, then mie_i set to 0x8 -> exactly one int_o with mcause_o = 0x80000003.
REQ-033 Edge on channel 5 in the same cycle as its ack clear -> pend_q[5] stays 1 and a second service of channel 5 follows.
REQ-034 rst_n_i pulsed low mid-SERVICE (asynchronously) -> int_o, mcause_o and irq_ack_o read 0 immediately; no ack pulse after release.
REQ-035 N_IRQ=1, irq_i=1 -> mcause_o = 0x80000000; int_rst_i in IDLE -> no state change.
